// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues a start bit,
// shifts out 8 data bits, odd parity and stop on device clock edges, then checks the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, BITS, PARITY, STOP, ACK, WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [3:0]       edge_q, edge_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic clk_meta, clk_sync, clk_prev;
    logic data_meta, data_sync;
    logic fall, active, timeout;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= i_ps2_clk;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= i_ps2_data;
            data_sync <= data_meta;
        end
    end

    assign fall    = clk_prev & ~clk_sync;
    assign active  = (state_q != IDLE) && (state_q != INHIBIT);
    assign timeout = active && (tmr_q == TMR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            parity_q  <= 1'b0;
            inh_q     <= '0;
            tmr_q     <= '0;
            edge_q    <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            inh_q     <= inh_d;
            tmr_q     <= tmr_d;
            edge_q    <= edge_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        parity_d  = parity_q;
        inh_d     = inh_q;
        tmr_d     = tmr_q;
        edge_d    = edge_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        if (active && tmr_q != TMR_MAX) tmr_d = tmr_q + TMR_W'(1);

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                inh_d     = '0;
                tmr_d     = '0;
                edge_d    = '0;
                if (i_valid) begin
                    data_d   = i_data;
                    parity_d = ~^i_data;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_q == INH_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    tmr_d     = '0;
                    state_d   = START;
                end else begin
                    inh_d = inh_q + INH_W'(1);
                end
            end
            START: if (fall) begin
                data_oe_d = ~data_q[0];
                edge_d    = 4'd1;
                state_d   = BITS;
            end
            BITS: if (fall) begin
                data_oe_d = ~data_q[edge_q[2:0]];
                edge_d    = edge_q + 4'd1;
                if (edge_q == 4'd7) state_d = PARITY;
            end
            PARITY: if (fall) begin
                data_oe_d = ~parity_q;
                edge_d    = edge_q + 4'd1;
                state_d   = STOP;
            end
            STOP: if (fall) begin
                data_oe_d = 1'b0;
                edge_d    = edge_q + 4'd1;
                state_d   = ACK;
            end
            ACK: if (fall) begin
                edge_d = edge_q + 4'd1;
                if (!data_sync) begin
                    state_d = WAIT_IDLE;
                end else begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_IDLE: if (clk_sync && data_sync) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A stuck transaction overrides whatever bus event landed this cycle.
        if (timeout) begin
            state_d   = IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            error_d   = 1'b1;
        end
    end

    assign o_ready       = (state_q == IDLE);
    assign o_busy        = ~o_ready;
    assign o_done        = done_q;
    assign o_error       = error_q;
    assign o_ps2_clk_oe  = clk_oe_q;
    assign o_ps2_data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// and a monitor matches each done/error pulse against the expected outcome queue.
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TMO = 600;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_data = '0;
    logic       i_valid = 1'b0;
    logic       o_ready, o_busy, o_done, o_error;
    logic       o_ps2_clk_oe, o_ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~o_ps2_clk_oe & ~dev_clk_low;
    assign ps2_data_line = ~o_ps2_data_oe & ~dev_data_low;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .i_ps2_clk(ps2_clk_line), .i_ps2_data(ps2_data_line),
        .o_ps2_clk_oe(o_ps2_clk_oe), .o_ps2_data_oe(o_ps2_data_oe)
    );

    always #5 clk = ~clk;

    typedef enum int { EV_DONE, EV_NACK, EV_TMO } ev_t;
    typedef struct { ev_t kind; logic [9:0] frame; } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         tests = 0;
    int         fails = 0;
    int         events = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         inh_len = 0;
    logic       prev_clk_oe = 1'b0;
    logic       prev_pulse = 1'b0;
    logic [9:0] obs_frame = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference frame: data LSB-first, then odd parity, then a released stop bit.
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            inh_len     = 0;
            prev_clk_oe = 1'b0;
            prev_pulse  = 1'b0;
        end else begin
            if (o_ps2_clk_oe) begin
                inh_len++;
            end else if (prev_clk_oe) begin
                check("inhibit_len", inh_len, INH);
                inh_len   = 0;
                start_cyc = cyc;
            end
            prev_clk_oe = o_ps2_clk_oe;

            if (o_done || o_error) begin
                events++;
                check("done_error_exclusive", {31'd0, o_done & o_error}, 0);
                check("pulse_one_cycle", {31'd0, prev_pulse}, 0);
                check("idle_at_pulse", {28'd0, o_ready, o_busy, o_ps2_clk_oe, o_ps2_data_oe}, 32'b1000);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {31'd0, o_done}, {31'd0, o_error});
                    check("unexpected_pulse_seen", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_is_done", {31'd0, o_done}, (e.kind == EV_DONE) ? 1 : 0);
                    if (e.kind == EV_TMO) check("timeout_cycles", cyc - start_cyc, TMO);
                    else                  check("frame", {22'd0, obs_frame}, {22'd0, e.frame});
                end
            end
            prev_pulse = o_done | o_error;
        end
    end

    task automatic send(input logic [7:0] d);
        int n = 0;
        while (!o_ready && n < 3000) begin @(negedge clk); n++; end
        check("ready_before_send", {31'd0, o_ready}, 1);
        @(negedge clk);
        i_data  = d;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic device_run(input bit ack, input int n_edges);
        int w = 0;
        while (!(o_ps2_clk_oe == 1'b0 && o_ps2_data_oe == 1'b1) && w < 3000) begin
            @(negedge clk); w++;
        end
        check("device_saw_start", (w < 3000) ? 1 : 0, 1);
        for (int k = 1; k <= n_edges; k++) begin
            if (k == 11 && ack) dev_data_low = 1'b1;
            repeat (8) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (8) @(negedge clk);
            if (k <= 10) obs_frame[k-1] = ps2_data_line;
            dev_clk_low = 1'b0;
        end
        if (n_edges >= 11) begin
            repeat (2) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_event(input int ev0);
        int n = 0;
        while (events == ev0 && n < 3000) begin @(negedge clk); n++; end
        check("response_seen", (events != ev0) ? 1 : 0, 1);
    endtask

    task automatic run_txn(input logic [7:0] d, input bit ack);
        int ev0 = events;
        exp_q.push_back('{kind: ack ? EV_DONE : EV_NACK, frame: frame_of(d)});
        fork
            send(d);
            device_run(ack, 11);
        join
        wait_event(ev0);
    endtask

    initial begin
        int ev0;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, o_ready}, 1);
        check("reset_busy", {31'd0, o_busy}, 0);
        check("reset_oe", {30'd0, o_ps2_clk_oe, o_ps2_data_oe}, 0);
        check("reset_pulses", {30'd0, o_done, o_error}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_txn(8'hED, 1'b1);
        run_txn(8'h01, 1'b1);
        run_txn(8'hFF, 1'b1);

        // Device never clocks after the host releases the clock line.
        ev0 = events;
        exp_q.push_back('{kind: EV_TMO, frame: '0});
        send(8'hA5);
        wait_event(ev0);

        run_txn(8'h3C, 1'b0);

        // A second request while busy must not disturb or follow the first.
        ev0 = events;
        exp_q.push_back('{kind: EV_DONE, frame: frame_of(8'hED)});
        fork
            send(8'hED);
            device_run(1'b1, 11);
            begin
                repeat (INH + 30) @(negedge clk);
                i_data  = 8'h55;
                i_valid = 1'b1;
                repeat (100) @(negedge clk);
                i_valid = 1'b0;
            end
        join
        wait_event(ev0);
        repeat (20) @(negedge clk);
        check("no_restart_after_ignored", {31'd0, o_busy}, 0);

        // Reset in the middle of the data bits.
        fork
            send(8'h96);
            device_run(1'b1, 4);
        join
        repeat (3) @(negedge clk);
        check("busy_before_reset", {31'd0, o_busy}, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_oe", {30'd0, o_ps2_clk_oe, o_ps2_data_oe}, 0);
        check("midreset_ready", {31'd0, o_ready}, 1);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_after_midreset", {31'd0, o_busy}, 0);

        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            bit         ack;
            d   = 8'($urandom_range(0, 255));
            ack = ($urandom_range(0, 3) != 0);
            run_txn(d, ack);
        end

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
